// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command engine.
//   - opcode byte values for the frame protocol
//   - command FSM state type
//   - status byte bit positions and a helper that packs the status byte
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_ERR  = 1;
  localparam int unsigned ST_OVR  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS_WAIT,
    S_RPOLL,
    S_RDATA,
    S_STAT,
    S_DRAIN
  } state_t;

  function automatic logic [7:0] status_byte(input logic busy, input logic err, input logic ovr);
    logic [7:0] s;
    s          = '0;
    s[ST_BUSY] = busy;
    s[ST_ERR]  = err;
    s[ST_OVR]  = ovr;
    return s;
  endfunction

endpackage

// File: rtl/spi_cmd_sync.sv
// Two-flop synchroniser for the raw SPI slave-select plus rising-edge detect.
// Ports:
//   ext_clk  - system clock
//   rst_n    - asynchronous active-low reset (flops reset to the idle/high level)
//   ss       - raw slave-select, high = frame idle
//   ss_sync  - synchronised slave-select
//   ss_rise  - one-cycle pulse on a 0->1 transition of ss_sync
module spi_cmd_sync (
  input  logic ext_clk,
  input  logic rst_n,
  input  logic ss,
  output logic ss_sync,
  output logic ss_rise
);

  logic meta_q;
  logic sync_q;
  logic sync_d;

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta_q <= ss;
      sync_q <= meta_q;
      sync_d <= sync_q;
    end
  end

  assign ss_sync = sync_q;
  assign ss_rise = sync_q & ~sync_d;

endmodule

// File: rtl/spi_cmd_engine.sv
// Byte-level SPI command decoder and 32-bit register-bus master.
// Parses opcode/address/data frames arriving on recv_data/recv_ready and
// issues one bus transaction per command; supplies the next MISO byte on
// send_data, loaded only on send_ready cycles.
// Ports:
//   ext_clk, rst_n           - clock, asynchronous active-low reset
//   ss                       - raw slave-select (high = idle), synchronised here
//   recv_data, recv_ready    - received byte and its one-cycle strobe
//   send_ready, send_data    - MISO load strobe and next MISO byte
//   bus_req/we/addr/wdata    - bus request, held until bus_ack
//   bus_rdata, bus_ack       - read data and one-cycle completion strobe
//   err                      - sticky bad-opcode flag (status bit1)
module spi_cmd_engine #(
  parameter int unsigned ADDR_BYTES  = 4,
  parameter logic [7:0]  READY_TOKEN = 8'hA5,
  parameter logic [7:0]  BUSY_TOKEN  = 8'h00
) (
  input  logic                    ext_clk,
  input  logic                    rst_n,
  input  logic                    ss,
  input  logic [7:0]              recv_data,
  input  logic                    recv_ready,
  input  logic                    send_ready,
  output logic [7:0]              send_data,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [31:0]             bus_wdata,
  input  logic [31:0]             bus_rdata,
  input  logic                    bus_ack,
  output logic                    err
);

  import spi_cmd_pkg::*;

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam logic [2:0]  ADDR_LAST = 3'(ADDR_BYTES - 1);

  logic ss_sync;
  logic ss_rise;

  spi_cmd_sync u_sync (
    .ext_clk (ext_clk),
    .rst_n   (rst_n),
    .ss      (ss),
    .ss_sync (ss_sync),
    .ss_rise (ss_rise)
  );

  state_t          state,    nxt_state;
  logic            is_read,  nxt_is_read;
  logic [2:0]      idx,      nxt_idx;
  logic [AW-1:0]   addr_sr,  nxt_addr_sr;
  logic [31:0]     wdata_sr, nxt_wdata_sr;
  logic [31:0]     rdata_q,  nxt_rdata;
  // req_own: the outstanding request belongs to the current frame.
  // req_pend: command complete but waiting for a stale request to be acked.
  logic            req_own,  nxt_req_own;
  logic            req_pend, nxt_req_pend;
  logic            nxt_bus_req;
  logic            nxt_bus_we;
  logic [AW-1:0]   nxt_bus_addr;
  logic [31:0]     nxt_bus_wdata;
  logic            err_q,    nxt_err;
  logic            ovr_q,    nxt_ovr;
  logic            cmd_done;
  logic            bus_free;
  logic [7:0]      resp;

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      is_read   <= 1'b0;
      idx       <= '0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rdata_q   <= '0;
      req_own   <= 1'b0;
      req_pend  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      send_data <= BUSY_TOKEN;
    end else begin
      state     <= nxt_state;
      is_read   <= nxt_is_read;
      idx       <= nxt_idx;
      addr_sr   <= nxt_addr_sr;
      wdata_sr  <= nxt_wdata_sr;
      rdata_q   <= nxt_rdata;
      req_own   <= nxt_req_own;
      req_pend  <= nxt_req_pend;
      bus_req   <= nxt_bus_req;
      bus_we    <= nxt_bus_we;
      bus_addr  <= nxt_bus_addr;
      bus_wdata <= nxt_bus_wdata;
      err_q     <= nxt_err;
      ovr_q     <= nxt_ovr;
      if (ss_sync) begin
        send_data <= BUSY_TOKEN;
      end else if (send_ready) begin
        send_data <= resp;
      end
    end
  end

  // Ack is resolved first so that a byte arriving in the same cycle is
  // interpreted against the post-ack state.
  always_comb begin
    nxt_state     = state;
    nxt_is_read   = is_read;
    nxt_idx       = idx;
    nxt_addr_sr   = addr_sr;
    nxt_wdata_sr  = wdata_sr;
    nxt_rdata     = rdata_q;
    nxt_req_own   = req_own;
    nxt_req_pend  = req_pend;
    nxt_bus_req   = bus_req;
    nxt_bus_we    = bus_we;
    nxt_bus_addr  = bus_addr;
    nxt_bus_wdata = bus_wdata;
    nxt_err       = err_q;
    nxt_ovr       = ovr_q;
    cmd_done      = 1'b0;
    bus_free      = !bus_req || bus_ack;

    if (bus_ack) begin
      nxt_bus_req = 1'b0;
    end

    if (ss_rise) begin
      // Frame end: drop partial command; an outstanding request completes on
      // its own and its read data is discarded.
      nxt_state    = S_IDLE;
      nxt_idx      = '0;
      nxt_req_own  = 1'b0;
      nxt_req_pend = 1'b0;
    end else begin
      if (bus_ack && req_own) begin
        nxt_req_own = 1'b0;
        if (is_read) begin
          nxt_rdata = bus_rdata;
          nxt_state = S_RPOLL;
        end else begin
          nxt_state = S_DRAIN;
        end
      end

      if (recv_ready && !ss_sync) begin
        case (nxt_state)
          S_IDLE: begin
            nxt_idx = '0;
            case (recv_data)
              OP_WRITE: begin
                nxt_is_read = 1'b0;
                nxt_state   = S_ADDR;
              end
              OP_READ: begin
                nxt_is_read = 1'b1;
                nxt_state   = S_ADDR;
              end
              OP_STATUS: nxt_state = S_STAT;
              default: begin
                nxt_err   = 1'b1;
                nxt_state = S_DRAIN;
              end
            endcase
          end
          S_ADDR: begin
            nxt_addr_sr = AW'({addr_sr, recv_data});
            if (idx == ADDR_LAST) begin
              nxt_idx = '0;
              if (is_read) begin
                cmd_done  = 1'b1;
                nxt_state = S_BUS_WAIT;
              end else begin
                nxt_state = S_WDATA;
              end
            end else if (idx != 3'd7) begin
              nxt_idx = idx + 3'd1;
            end
          end
          S_WDATA: begin
            nxt_wdata_sr = {wdata_sr[23:0], recv_data};
            if (idx == 3'd3) begin
              nxt_idx   = '0;
              cmd_done  = 1'b1;
              nxt_state = S_BUS_WAIT;
            end else begin
              nxt_idx = idx + 3'd1;
            end
          end
          S_BUS_WAIT: begin
            if (!is_read) begin
              nxt_ovr = 1'b1;
            end
          end
          S_RPOLL: begin
            // Only the byte exchanged while READY_TOKEN was on MISO starts
            // the data phase; earlier polls saw BUSY_TOKEN.
            if (send_data == READY_TOKEN) begin
              nxt_idx   = '0;
              nxt_state = S_RDATA;
            end
          end
          S_RDATA: begin
            if (idx == 3'd3) begin
              nxt_state = S_DRAIN;
            end else begin
              nxt_idx = idx + 3'd1;
            end
          end
          S_STAT: begin
            nxt_err   = 1'b0;
            nxt_ovr   = 1'b0;
            nxt_state = S_DRAIN;
          end
          default: ;
        endcase
      end

      if ((cmd_done || req_pend) && bus_free) begin
        nxt_bus_req  = 1'b1;
        nxt_req_own  = 1'b1;
        nxt_req_pend = 1'b0;
        nxt_bus_we   = !nxt_is_read;
        nxt_bus_addr = nxt_addr_sr;
        if (!nxt_is_read) begin
          nxt_bus_wdata = nxt_wdata_sr;
        end
      end else if (cmd_done) begin
        nxt_req_pend = 1'b1;
      end
    end
  end

  // Response for the next MISO slot, based on the state after this cycle.
  // RPOLL is only entered once read data has been latched.
  always_comb begin
    resp = BUSY_TOKEN;
    case (nxt_state)
      S_RPOLL: resp = READY_TOKEN;
      S_RDATA: begin
        case (nxt_idx[1:0])
          2'd0:    resp = nxt_rdata[31:24];
          2'd1:    resp = nxt_rdata[23:16];
          2'd2:    resp = nxt_rdata[15:8];
          default: resp = nxt_rdata[7:0];
        endcase
      end
      S_STAT:  resp = status_byte(nxt_bus_req, nxt_err, nxt_ovr);
      default: resp = BUSY_TOKEN;
    endcase
  end

  assign err = err_q;

endmodule

// File: doc/spi_cmd_engine.md
Name: spi_cmd_engine

Overview:
Byte-level command decoder sitting directly downstream of the SPI slave, in the ext_clk domain. Consumes each received byte (recv_data/recv_ready), parses a small opcode/address/data frame protocol, and masters one 32-bit register-bus transaction per command. Supplies the next MISO byte on send_data under the slave's send_ready rule. Gives the host read and write access to the SoC register space over SPI.

Parameters:
ADDR_BYTES, 4, address bytes per frame, MSB first (1..4); bus_addr width = 8*ADDR_BYTES
READY_TOKEN, 8'hA5, poll byte meaning "read data follows"
BUSY_TOKEN, 8'h00, poll/filler byte

Ports:
ext_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ss  in  1  raw SPI slave-select, high = frame idle; 2-flop synced internally
recv_data  in  8  byte from SPI slave
recv_ready  in  1  one-cycle strobe, recv_data valid
send_ready  in  1  SPI slave may sample send_data this cycle
send_data  out  8  next MISO byte
bus_req  out  1  transaction request, held until bus_ack
bus_we  out  1  1 = write
bus_addr  out  8*ADDR_BYTES  byte address
bus_wdata  out  32  write data
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  one-cycle completion strobe
err  out  1  sticky protocol-error flag, mirrors status bit1

Behaviour:
- Reset: send_data=BUSY_TOKEN, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, err=0, state=IDLE, status bits cleared.
- Frame: ss_sync high = idle. A 0->1 transition of ss_sync returns the FSM to IDLE and discards partial address/data. An outstanding bus_req stays asserted until bus_ack; its read data is discarded.
- Opcodes (first byte of frame): 0x01 WRITE = addr[ADDR_BYTES] + data[4], MSB first; 0x02 READ = addr[ADDR_BYTES], then poll bytes; 0x03 STATUS = next byte returns the status. Any other opcode sets status bit1 (err) and moves to DRAIN.
- FSM states: IDLE, ADDR, WDATA, BUS_WAIT, RPOLL, RDATA, STAT, DRAIN.
  - IDLE -> ADDR on opcode 0x01/0x02; IDLE -> STAT on 0x03.
  - ADDR: shift address bytes in. After the last byte: WRITE -> WDATA; READ -> BUS_WAIT with bus_req=1, we=0.
  - WDATA: after 4 bytes, bus_req=1, we=1 -> BUS_WAIT.
  - BUS_WAIT -> on bus_ack, drop bus_req the same edge. READ latches bus_rdata and goes to RPOLL. WRITE goes to DRAIN.
  - RPOLL: returns READY_TOKEN if data latched, else BUSY_TOKEN; the byte after READY_TOKEN starts RDATA.
  - RDATA: 4 bytes MSB first -> DRAIN.
  - DRAIN / STAT: ignore received bytes until ss_sync rises.
- Host polling: the host clocks dummy bytes during RPOLL and receives BUSY_TOKEN until READY_TOKEN is returned.
- Status byte: bit0 busy (bus_req), bit1 err (bad opcode), bit2 ovr (new byte arrived while BUS_WAIT on WRITE). bit1 and bit2 are cleared when STATUS is returned. bits 7:3 = 0.
- send_data:
  - Updated only in cycles where send_ready=1; stable otherwise.
  - Value = response byte for the next slot given the state after the last consumed byte.
  - BUSY_TOKEN in all states except RPOLL, RDATA and STAT.
  - If ss_sync is high, send_data = BUSY_TOKEN.
- Simultaneous events: recv_ready in the same cycle as ss_sync rising is ignored. bus_ack in the same cycle as recv_ready processes the ack first, then the byte sees the updated state.
- One outstanding bus transaction; a new command is not issued while bus_req=1. An opcode arriving then is accepted, and bus_req re-asserts only after the ack.
- Counters: 3-bit byte index, saturating; no wrap inside a frame.

Decomposition:
- Shared package spi_cmd_pkg: opcode constants (OP_WRITE/OP_READ/OP_STATUS), state enum, status bit indices.
- One natural sub-module: spi_cmd_sync (2-flop ss synchroniser with rise detect).

Test Plan:
1. After reset deassert: send_data=8'h00, bus_req=0, err=0.
2. WRITE frame 01 12 34 56 78 DE AD BE EF -> one bus_req with we=1, addr=32'h12345678, wdata=32'hDEADBEEF; bus_req drops on the ack cycle.
3. READ 02 00 00 00 10, bus_ack after 20 cycles with rdata=32'hCAFEF00D, host polls -> 00… A5 CA FE F0 0D.
4. Opcode 8'h7F then ss idle, then 03 xx -> err=1; status byte returns 8'h02; err=0 afterwards.
5. ss rises after 2 address bytes of a READ -> no bus_req. The next frame 03 xx returns 8'h00.
6. rst_n low during BUS_WAIT -> all outputs return to reset values asynchronously; a bus_ack after reset causes no state change.
